aes_mmio_issuer: RTL and testbench

Upstream command sequencer for the AES accelerator's 8-bit MMIO port. It accepts one host transaction at a time over a valid/ready request channel and drives `stb`/`wr`/`addr`/`data_in` into the accelerator. It pulses `issue` in the same cycle as the instruction strobe; that pulse feeds the instruction decoder's `__ISSUE__` input. It can optionally poll the status register after a write until the accelerator goes idle, then returns read data, status or error on a valid/ready response channel.

---
 rtl/aes_mmio_pkg.sv | 28 ++
 rtl/aes_mmio_issuer.sv | 138 +++++++++++++
 tb/tb_aes_mmio_issuer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_mmio_pkg.sv
// Shared definitions for the AES accelerator MMIO command path:
// command encodings, register map and the issuer FSM state type.
package aes_mmio_pkg;

    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam logic [15:0] REG_START  = 16'hff00;
    localparam logic [15:0] REG_STATUS = 16'hff01;
    localparam logic [15:0] REG_ADDR   = 16'hff02;
    localparam logic [15:0] REG_LEN    = 16'hff04;
    localparam logic [15:0] REG_KEY    = 16'hff10;
    localparam logic [15:0] REG_CTR    = 16'hff20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCESS   = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_POLL_REQ = 3'd3,
        ST_POLL_CHK = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    function automatic logic cmd_legal(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/aes_mmio_issuer.sv
// Host-to-accelerator MMIO sequencer: one transaction at a time, optional
// status polling after writes, single response per accepted request.
module aes_mmio_issuer
    import aes_mmio_pkg::*;
#(
    parameter logic [15:0] STATUS_ADDR = REG_STATUS,
    parameter logic [15:0] POLL_MAX    = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_data,
    input  logic        req_poll,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        stb,
    output logic        wr,
    output logic [15:0] addr,
    output logic [7:0]  data_in,
    input  logic [7:0]  data_out,
    output logic        issue,
    output logic        busy
);

    state_e      r_state;
    logic [1:0]  r_cmd;
    logic        r_poll;
    logic [15:0] r_addr;
    logic [7:0]  r_data_in;
    logic [15:0] r_poll_cnt;
    logic [7:0]  r_rsp_data;
    logic        r_rsp_err;

    logic        w_access;
    logic        w_poll_req;

    assign w_access   = (r_state == ST_ACCESS);
    assign w_poll_req = (r_state == ST_POLL_REQ);

    // Strobes decode straight from state so an async reset kills them at once.
    assign stb       = w_access || w_poll_req;
    assign issue     = w_access;
    assign wr        = w_access && (r_cmd == CMD_WRITE);
    assign addr      = r_addr;
    assign data_in   = r_data_in;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != ST_IDLE);
    // NOTE: the reset state is IDLE, so ready must also be masked by rst
    // itself to read 0 for the whole time reset is held.
    assign req_ready = (r_state == ST_IDLE) && !rst;

    // NOTE: every state register uses <= so all updates land together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_poll     <= 1'b0;
            r_addr     <= '0;
            r_data_in  <= '0;
            r_poll_cnt <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_cmd  <= req_cmd;
                        r_poll <= req_poll;
                        if (cmd_legal(req_cmd)) begin
                            // Bus address/data only move when a strobe follows.
                            r_addr    <= req_addr;
                            r_data_in <= req_data;
                            r_state   <= ST_ACCESS;
                        end else begin
                            r_rsp_data <= 8'h00;
                            r_rsp_err  <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (r_cmd == CMD_READ) begin
                        r_state <= ST_CAPTURE;
                    end else if (r_poll) begin
                        r_poll_cnt <= '0;
                        r_addr     <= STATUS_ADDR;
                        r_state    <= ST_POLL_REQ;
                    end else begin
                        r_rsp_data <= 8'h00;
                        r_rsp_err  <= 1'b0;
                        r_state    <= ST_RESP;
                    end
                end

                ST_CAPTURE: begin
                    r_rsp_data <= data_out;
                    r_rsp_err  <= 1'b0;
                    r_state    <= ST_RESP;
                end

                ST_POLL_REQ: begin
                    r_poll_cnt <= (r_poll_cnt == 16'hffff) ? r_poll_cnt : r_poll_cnt + 16'd1;
                    r_state    <= ST_POLL_CHK;
                end

                ST_POLL_CHK: begin
                    r_rsp_data <= data_out;
                    if (data_out[1:0] == 2'b00) begin
                        r_rsp_err <= 1'b0;
                        r_state   <= ST_RESP;
                    end else if (r_poll_cnt == POLL_MAX) begin
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_state <= ST_POLL_REQ;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mmio_issuer.sv
// Directed bench for aes_mmio_issuer: a cycle-indexed transaction schedule
// derived from the protocol latencies, checked every cycle, plus literal pins.
module tb_aes_mmio_issuer;
    import aes_mmio_pkg::*;

    localparam logic [15:0] TB_POLL_MAX = 16'd4;
    localparam int TBL_N = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = '0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        req_poll = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        stb;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out = '0;
    logic        issue;
    logic        busy;

    aes_mmio_issuer #(
        .STATUS_ADDR(REG_STATUS),
        .POLL_MAX   (TB_POLL_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd  (req_cmd),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_poll (req_poll),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .stb      (stb),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .issue    (issue),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  cmd;
        logic [15:0] a;
        logic [7:0]  d;
        logic        p;
        logic        rr;
        logic [7:0]  dout;
        logic        rdy;
        logic        bsy;
        logic        stb;
        logic        wr;
        logic        iss;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        rv;
        logic [7:0]  rd;
        logic        re;
    } cyc_t;

    cyc_t        tbl[TBL_N];
    int          t_next = 0;
    int          tbl_len = 0;
    logic [15:0] h_addr = '0;
    logic [7:0]  h_din = '0;
    logic [7:0]  st_q[$];

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    logic prev_rv = 1'b0;

    int          stb_log[$];
    int          iss_log[$];
    int          rv_log[$];
    logic [7:0]  rd_log[$];
    logic        re_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Default cycle: host idle with junk on the request bus, bus quiet and held.
    task automatic fill(input int c, input logic b);
        tbl[c].v    = 1'b0;
        tbl[c].cmd  = 2'd3;
        tbl[c].a    = 16'hdead;
        tbl[c].d    = 8'hee;
        tbl[c].p    = 1'b1;
        tbl[c].rr   = 1'b0;
        tbl[c].dout = 8'h5e;
        tbl[c].rdy  = !b;
        tbl[c].bsy  = b;
        tbl[c].stb  = 1'b0;
        tbl[c].wr   = 1'b0;
        tbl[c].iss  = 1'b0;
        tbl[c].addr = h_addr;
        tbl[c].din  = h_din;
        tbl[c].rv   = 1'b0;
        tbl[c].rd   = 8'h00;
        tbl[c].re   = 1'b0;
    endtask

    // Schedule one transaction from the protocol's latency rules; status or
    // read values are taken from st_q in order.
    task automatic plan_txn(input logic [1:0] cmd, input logic [15:0] a, input logic [7:0] d,
                            input logic p, input int gap, input int wait_n);
        int         c;
        int         k;
        logic [7:0] rdat;
        logic       rerr;
        bit         done;
        c = t_next;
        for (int i = 0; i < gap; i++) begin
            fill(c, 1'b0);
            c++;
        end
        fill(c, 1'b0);
        tbl[c].v   = 1'b1;
        tbl[c].cmd = cmd;
        tbl[c].a   = a;
        tbl[c].d   = d;
        tbl[c].p   = p;
        c++;
        rdat = 8'h00;
        rerr = 1'b0;
        if (cmd == CMD_READ || cmd == CMD_WRITE) begin
            h_addr = a;
            h_din  = d;
            fill(c, 1'b1);
            tbl[c].stb = 1'b1;
            tbl[c].iss = 1'b1;
            tbl[c].wr  = (cmd == CMD_WRITE);
            c++;
            if (cmd == CMD_READ) begin
                fill(c, 1'b1);
                rdat = st_q.pop_front();
                tbl[c].dout = rdat;
                c++;
            end else if (p) begin
                k = 0;
                done = 1'b0;
                while (!done && k < 64) begin
                    k++;
                    h_addr = REG_STATUS;
                    fill(c, 1'b1);
                    tbl[c].stb = 1'b1;
                    c++;
                    fill(c, 1'b1);
                    rdat = st_q.pop_front();
                    tbl[c].dout = rdat;
                    c++;
                    if (rdat[1:0] == 2'b00) begin
                        done = 1'b1;
                    end else if (k == int'(TB_POLL_MAX)) begin
                        rerr = 1'b1;
                        done = 1'b1;
                    end
                end
            end
        end else begin
            rerr = 1'b1;
        end
        for (int i = 0; i <= wait_n; i++) begin
            fill(c, 1'b1);
            tbl[c].rv = 1'b1;
            tbl[c].rd = rdat;
            tbl[c].re = rerr;
            tbl[c].rr = (i == wait_n);
            c++;
        end
        t_next = c;
    endtask

    task automatic drive(input int c);
        req_valid = tbl[c].v;
        req_cmd   = tbl[c].cmd;
        req_addr  = tbl[c].a;
        req_data  = tbl[c].d;
        req_poll  = tbl[c].p;
        rsp_ready = tbl[c].rr;
        data_out  = tbl[c].dout;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, tbl[cyc].rdy);
            check("busy",      busy,      tbl[cyc].bsy);
            check("stb",       stb,       tbl[cyc].stb);
            check("wr",        wr,        tbl[cyc].wr);
            check("issue",     issue,     tbl[cyc].iss);
            check("addr",      addr,      tbl[cyc].addr);
            check("data_in",   data_in,   tbl[cyc].din);
            check("rsp_valid", rsp_valid, tbl[cyc].rv);
            if (tbl[cyc].rv) begin
                check("rsp_data", rsp_data, tbl[cyc].rd);
                check("rsp_err",  rsp_err,  tbl[cyc].re);
            end
            if (stb) stb_log.push_back(cyc);
            if (issue) iss_log.push_back(cyc);
            if (rsp_valid && !prev_rv) begin
                rv_log.push_back(cyc);
                rd_log.push_back(rsp_data);
                re_log.push_back(rsp_err);
            end
            prev_rv = rsp_valid;
        end
    end

    int         pin_stb[13] = '{2, 6, 11, 12, 14, 16, 21, 22, 24, 26, 28, 43, 46};
    int         pin_iss[6]  = '{2, 6, 11, 21, 43, 46};
    int         pin_rv[8]   = '{3, 8, 18, 30, 33, 41, 44, 47};
    logic [7:0] pin_rd[8]   = '{8'h00, 8'ha5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       pin_re[8]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        // Schedule
        plan_txn(CMD_WRITE, REG_ADDR, 8'h34, 1'b0, 1, 0);
        st_q.push_back(8'ha5);
        plan_txn(CMD_READ, REG_KEY, 8'h00, 1'b0, 1, 0);
        st_q.push_back(8'h01); st_q.push_back(8'h01); st_q.push_back(8'h00);
        plan_txn(CMD_WRITE, REG_START, 8'h01, 1'b1, 1, 0);
        for (int i = 0; i < 4; i++) st_q.push_back(8'h02);
        plan_txn(CMD_WRITE, REG_LEN, 8'h77, 1'b1, 1, 0);
        plan_txn(2'd3, REG_START, 8'h99, 1'b0, 1, 5);
        plan_txn(2'd0, REG_START, 8'h98, 1'b1, 1, 0);
        plan_txn(CMD_WRITE, REG_CTR, 8'h55, 1'b0, 0, 0);
        plan_txn(CMD_WRITE, REG_KEY, 8'h66, 1'b0, 0, 0);
        fill(t_next, 1'b0);
        tbl_len = t_next + 1;

        // Outputs while reset is held
        repeat (2) @(posedge clk);
        #2;
        check("reset_outs",
              {req_ready, rsp_valid, rsp_data, rsp_err, stb, wr, addr, data_in, issue, busy},
              '0);

        // Play the schedule
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        drive(0);
        chk_en = 1'b1;
        for (int c = 1; c < tbl_len; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            drive(c);
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        // Literal pins on latency and response contents
        check("stb_count", stb_log.size(), 13);
        for (int i = 0; i < 13 && i < stb_log.size(); i++) check("stb_cycle", stb_log[i], pin_stb[i]);
        check("issue_count", iss_log.size(), 6);
        for (int i = 0; i < 6 && i < iss_log.size(); i++) check("issue_cycle", iss_log[i], pin_iss[i]);
        check("rsp_count", rv_log.size(), 8);
        for (int i = 0; i < 8 && i < rv_log.size(); i++) begin
            check("rsp_cycle", rv_log[i], pin_rv[i]);
            check("rsp_data_pin", rd_log[i], pin_rd[i]);
            check("rsp_err_pin", re_log[i], pin_re[i]);
        end

        // Reset asserted during a status poll strobe
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_cmd = CMD_WRITE; req_addr = REG_START;
        req_data = 8'h01; req_poll = 1'b1; rsp_ready = 1'b1; data_out = 8'h03;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("poll_req_stb", stb, 1'b1);
        check("poll_req_issue", issue, 1'b0);
        check("poll_req_addr", addr, REG_STATUS);
        #2;
        rst = 1'b1;
        #1;
        check("rst_stb", stb, 1'b0);
        check("rst_issue", issue, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 1'b0);
            check("post_rst_no_stb", stb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
